// File: rtl/nem_ohmux_ctrl_pkg.sv
// nem_ohmux_ctrl_pkg: shared state encoding and counter sizing for the NEM relay mux select controller.
package nem_ohmux_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MAKE,
        ACTIVE,
        PARKED,
        BREAK
    } state_e;

    function automatic int cnt_width(input int make_cyc, input int break_cyc);
        return $clog2((make_cyc > break_cyc ? make_cyc : break_cyc) + 1);
    endfunction

endpackage

// File: rtl/nem_rr_arb2.sv
// nem_rr_arb2: combinational two-way round-robin picker; on a tie the requester not served last wins.
module nem_rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       valid_o,
    output logic       pick_o
);

    assign valid_o = |req_i;
    assign pick_o  = (&req_i) ? ~last_i : req_i[1];

endmodule

// File: rtl/nem_ohmux_sel_ctrl.sv
// nem_ohmux_sel_ctrl: one-hot select sequencer and REQ/GNT arbiter for the NEM-relay inverting mux,
// enforcing break-before-make settle times on the mechanical relays.
module nem_ohmux_sel_ctrl
    import nem_ohmux_ctrl_pkg::*;
#(
    parameter int MAKE_CYC  = 6,
    parameter int BREAK_CYC = 4,
    parameter bit PARK      = 1'b1
) (
    input  logic       CP,
    input  logic       RST,
    input  logic [1:0] REQ,
    output logic [1:0] GNT,
    output logic       S0,
    output logic       S1,
    output logic       BUSY
);

    localparam int CW = cnt_width(MAKE_CYC, BREAK_CYC);
    localparam logic [CW-1:0] MAKE_LD  = CW'(MAKE_CYC - 1);
    localparam logic [CW-1:0] BREAK_LD = CW'(BREAK_CYC - 1);

    state_e        state_q, state_d, rel_state;
    logic          owner_q, owner_d, last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          arb_valid, arb_pick, own_req, oth_req, cnt_done, closed_d;

    nem_rr_arb2 u_arb (
        .req_i  (REQ),
        .last_i (last_q),
        .valid_o(arb_valid),
        .pick_o (arb_pick)
    );

    assign own_req   = REQ[owner_q];
    assign oth_req   = REQ[~owner_q];
    assign cnt_done  = cnt_q == '0;
    // A waiting rival always forces a break; parking only happens when nobody else wants the mux.
    assign rel_state = (oth_req || !PARK) ? BREAK : PARKED;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d = MAKE;
                    owner_d = arb_pick;
                    cnt_d   = MAKE_LD;
                end
            end
            MAKE: begin
                if (!cnt_done) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (own_req) begin
                    state_d = ACTIVE;
                    last_d  = owner_q;
                end else begin
                    state_d = rel_state;
                    cnt_d   = BREAK_LD;
                end
            end
            ACTIVE: begin
                if (!own_req) begin
                    state_d = rel_state;
                    cnt_d   = BREAK_LD;
                end
            end
            PARKED: begin
                if (oth_req) begin
                    state_d = BREAK;
                    cnt_d   = BREAK_LD;
                end else if (own_req) begin
                    state_d = ACTIVE;
                    last_d  = owner_q;
                end
            end
            BREAK: begin
                if (!cnt_done) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (arb_valid) begin
                    state_d = MAKE;
                    owner_d = arb_pick;
                    cnt_d   = MAKE_LD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign closed_d = state_d inside {MAKE, ACTIVE, PARKED};

    // Outputs are decoded from next state so they change on the same edge as the state.
    always_ff @(posedge CP) begin
        if (RST) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            S0      <= 1'b0;
            S1      <= 1'b0;
            GNT     <= 2'b00;
            BUSY    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            S0      <= closed_d && !owner_d;
            S1      <= closed_d && owner_d;
            GNT     <= {state_d == ACTIVE && owner_d, state_d == ACTIVE && !owner_d};
            BUSY    <= state_d inside {MAKE, BREAK};
        end
    end

endmodule
